// File: rtl/if_stage_pq.sv
// if_stage_pq: instruction fetch stage with a prefetch queue.
// One request in flight; responses are buffered so ID stalls do not stop fetch.
module if_stage_pq #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            discard;
    logic [AW:0]     count;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [XLEN-1:0] q_pc  [DEPTH];
    logic [31:0]     q_ins [DEPTH];

    logic            live;
    logic [AW:0]     occ;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Issue, push and pop decisions for this cycle
    always_comb begin
        live           = outstanding && !discard;
        occ            = count + {{AW{1'b0}}, live};
        imem_req_valid = reset && !pc_src
                         && (!outstanding || imem_rsp_valid)
                         && (occ < FULL);
        imem_req_addr  = fpc;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && live && !pc_src;
        pop            = (count != '0) && !stall && !pc_src;
    end

    // Head of queue drives the ID-facing outputs; NOP bubble when empty
    always_comb begin
        valid_out = (count != '0);
        pc_out    = '0;
        instr_out = NOP;
        if (valid_out) begin
            pc_out    = q_pc[head];
            instr_out = q_ins[head];
        end
    end

    // Queue payload storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]  <= req_pc;
            q_ins[tail] <= imem_rsp_data;
        end
    end

    // Fetch PC, in-flight tracking and queue pointers; redirect wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc         <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (pc_src) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            fpc   <= next_pc & ~XLEN'(3);
            if (imem_rsp_valid) begin
                outstanding <= 1'b0;
            end else if (outstanding) begin
                discard <= 1'b1;
            end
        end else begin
            if (req_fire) begin
                req_pc      <= fpc;
                fpc         <= fpc + XLEN'(4);
                outstanding <= 1'b1;
                discard     <= 1'b0;
            end else if (imem_rsp_valid) begin
                outstanding <= 1'b0;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + ONE;
            end else if (pop && !push) begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: doc/if_stage_pq.md
# if_stage_pq

Parametrised instruction-fetch stage for the 5-stage pipeline, successor to `if_stage`. It generates fetch PCs and issues them to instruction memory over a valid/ready request channel, then accepts responses that can arrive after a variable number of cycles. Fetched instructions are buffered in a DEPTH-entry prefetch queue so that ID-stage stalls do not stop memory traffic. Redirects from EX (`pc_src`) flush the queue and squash any in-flight response.

## Interface
- `XLEN`, 32: PC / address width.
- `DEPTH`, 4: prefetch queue entries; must be a power of 2 and ≥ 2.
- `RESET_PC`, 0: first fetch address after reset.
- `NOP`, 32'h0000_0013: instruction driven on `instr_out` when no entry is valid.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `stall`  in  1  ID cannot accept this cycle.
- `pc_src`  in  1  redirect request.
- `next_pc`  in  XLEN  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  XLEN  fetch address, always word aligned.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response data valid, returned in request order.
- `imem_rsp_data`  in  32  fetched instruction.
- `valid_out`  out  1  `pc_out`/`instr_out` hold a real instruction.
- `pc_out`  out  XLEN  PC of the queue head.
- `instr_out`  out  32  instruction at the queue head.

## Operation
- **State:**
  - `fpc`: next fetch PC.
  - Queue of {pc, instr} entries with `count` in 0..DEPTH.
  - `outstanding` flag (at most one request in flight), plus `req_pc` for that request.
  - `discard` flag, marking the in-flight response as stale.
- **Request issue:**
  - `imem_req_valid` = !`pc_src` && (!`outstanding` || `imem_rsp_valid`) && (`count` + (`outstanding` && !`discard`) < DEPTH).
  - `imem_req_addr` = `fpc`.
- **Handshake:** when valid && ready, `req_pc` ← `fpc`, `fpc` ← `fpc` + 4 (wraps mod 2^XLEN), `outstanding` ← 1, `discard` ← 0.
- **Backpressure:** while valid && !ready and there is no redirect, the address stays stable.
- **Response, live:** `imem_rsp_valid` with `outstanding` && !`discard` && !`pc_src` pushes {`req_pc`, `imem_rsp_data`}.
- **Response, stale:** a response that is discarded, or that arrives in a `pc_src` cycle, is dropped.
- **Response bookkeeping:**
  - `outstanding` clears on any response, unless a new request is accepted in the same cycle.
  - `imem_rsp_valid` while `outstanding` = 0 is ignored.
- **Output:**
  - `valid_out` = (`count` != 0).
  - When the queue is non-empty, `pc_out`/`instr_out` = head entry.
  - When the queue is empty, `pc_out` = 0 and `instr_out` = NOP.
- **Pop:** the head is popped when `valid_out` && !`stall` && !`pc_src`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect** (`pc_src` = 1) takes priority over pop, push and issue:
  - Queue emptied (`count` ← 0).
  - `fpc` ← {`next_pc`[XLEN-1:2], 2'b00}.
  - If a request is in flight and its response does not arrive this cycle, `discard` ← 1.
- **Full queue:** issue stops once `count` plus the live in-flight request reaches DEPTH, so the queue never overflows. There is no underflow, because pop requires `valid_out`.

## Timing
- **Reset values** (asserted asynchronously):
  - `fpc` = RESET_PC, `count` = 0, `outstanding` = 0, `discard` = 0.
  - Outputs: `valid_out` = 0, `pc_out` = 0, `instr_out` = NOP, `imem_req_valid` = 0.
- **First cycle after release:** `imem_req_valid` = 1 and `imem_req_addr` = RESET_PC.
- **Response to output:** 1 cycle. A response pushed at edge k is visible on the outputs after edge k.
- **Redirect at edge n, zero-wait memory** (ready = 1, response one cycle after acceptance):
  - Request to the target issued in cycle n+1.
  - Response in cycle n+2.
  - `valid_out` = 1 with `pc_out` = target in cycle n+3.
- **Steady state:** with zero-wait memory and no stall, one instruction per cycle after the initial fill.
- **Reset mid-operation:** all state is cleared immediately. Any response arriving after release is ignored, since `outstanding` = 0.

## Test plan
- **Reset and stream:** release reset, memory has ready = 1 and answers one cycle later with data = addr ^ 32'hA5A5_0000. Required: `valid_out` rises on the third cycle, then `pc_out` = 0, 4, 8, 0xC on consecutive cycles with matching `instr_out`.
- **Stall fill:** hold `stall` = 1 from cycle 2 with DEPTH = 4. Required:
  - `count` reaches 4 and `imem_req_valid` stays 0.
  - The head holds pc 0 with the correct `instr_out`.
  - After `stall` drops, pcs 0, 4, 8, 0xC come out in order with none lost.
- **Redirect with in-flight request:** memory latency 3 cycles, `pc_src` = 1 with `next_pc` = 0x12 while a request to 0x8 is outstanding. Required:
  - The 0x8 response is dropped.
  - The next request address is 0x10, and the first valid `pc_out` is 0x10.
- **Redirect coinciding with response:** `pc_src` and `imem_rsp_valid` in the same cycle. Required: the response is not pushed and `valid_out` = 0 on the next cycle.
- **Backpressure:** `imem_req_ready` = 0 for 5 cycles. Required: `imem_req_addr` holds stable with valid = 1, and `fpc` advances only once ready = 1.
- **Reset mid-stream:** assert `reset` = 0 with the queue holding 3 entries. Required:
  - `valid_out` = 0 and `instr_out` = 0x13 immediately.
  - Fetch restarts at RESET_PC after release.
